rgb_pwm_driver: RTL and testbench
=================================

// Module: rgb_pwm_driver
// PURPOSE
//   Downstream consumer of the three 4-bit button-driven colour values (red/green/blue).
//   Turns each value into a PWM duty cycle driving one LED channel, in the system clock domain.
//   Values arrive asynchronous to clk (they are produced in button-edge domains).
//   The block therefore synchronises them and filters for stability.
//   New duties are applied only at PWM period boundaries, so the LEDs never glitch.
// PARAMETERS
//   WIDTH     4    bit width of each colour value; MAXSTEP = 2**WIDTH-1 steps per PWM period
//   PRESCALE  256  clk cycles per PWM step; legal range >= 1 (1 = one step every clk)
// PORTS
//   clk         in   1      system clock, all state on posedge
//   reset       in   1      asynchronous, active-high; clears all state immediately
//   val_red     in   WIDTH  red value, asynchronous to clk
//   val_green   in   WIDTH  green value, asynchronous to clk
//   val_blue    in   WIDTH  blue value, asynchronous to clk
//   led_red     out  1      red PWM output, registered
//   led_green   out  1      green PWM output, registered
//   led_blue    out  1      blue PWM output, registered
//   period_start out 1      one-clk pulse, first cycle of each new PWM period, registered
// BEHAVIOUR
//   Reset (async, any time, including mid-period):
//     - sync/shadow/duty regs, presc_cnt, step_cnt, all led_* and period_start -> 0.
//     - Operation resumes at presc_cnt=0, step_cnt=0 on the first clk after reset deasserts.
//   Input capture, per channel, identical and independent:
//     - Path s1 -> s2 -> s3, each WIDTH bits.
//     - shadow <= s2 only when s2 == s3 (stable two consecutive samples); otherwise shadow holds.
//     - A changing multi-bit value is never captured mid-transition.
//   Prescaler:
//     - presc_cnt counts 0..PRESCALE-1 and wraps.
//     - tick = (presc_cnt == PRESCALE-1).
//   Step counter, advances only on tick:
//     - step_cnt counts 0..MAXSTEP-1.
//     - On tick with step_cnt == MAXSTEP-1: step_cnt <= 0, duty_x <= shadow_x for all 3 channels,
//       period_start <= 1.
//     - Otherwise on tick: step_cnt <= step_cnt+1.
//     - period_start is 0 in every other cycle.
//   Outputs:
//     - Every clk: led_x <= (step_cnt < duty_x), unsigned WIDTH-bit compare.
//     - 1-clk latency from step_cnt/duty to pin.
//   Duty rules (period = MAXSTEP*PRESCALE clks):
//     - duty 0 -> LED constantly 0.
//     - duty MAXSTEP (all ones) -> LED constantly 1, no low pulse at boundaries.
//     - duty d -> high for exactly d*PRESCALE clks per period.
//   Latency:
//     - Input change -> shadow: 3-4 clks.
//     - shadow -> duty: at the next period boundary (worst case one full period).
//     - Input changes faster than 2 clks are not captured until the value settles.
//   Simultaneous events:
//     - A shadow update in the same cycle as the boundary load: duty takes the OLD shadow;
//       the new value applies at the following boundary.
//   No wrap hazards: all counters wrap only at their stated maxima.
//     - duty is never compared against a value outside 0..MAXSTEP.
// TESTING (bench uses WIDTH=4, PRESCALE=2 -> MAXSTEP=15, period=30 clks)
//   1. Assert reset mid-period with led_red=1 -> all outputs 0 in the same cycle, before any clk edge;
//      first period_start 30 clks after release.
//   2. val_red=0, val_green=15, val_blue=5, steady -> after the first loaded period:
//      led_red always 0, led_green always 1, led_blue high exactly 10 of every 30 clks.
//   3. period_start pulses exactly 1 clk wide, every 30 clks.
//      LED rising edges align 1 clk after each period_start.
//   4. Change val_blue 5->9 mid-period -> current period keeps 10 high clks;
//      next period has 18 high clks; no partial period.
//   5. Toggle val_red every clk (3,12,3,12...) -> shadow_red never updates; led_red unchanged;
//      then hold 12 -> duty 12 (24 high clks) from the next boundary.
//   6. PRESCALE=1 build, val_green=1 -> led_green high 1 clk per 15-clk period.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel LED PWM driver for colour values that arrive
// asynchronously to clk. New duties take effect only at PWM period boundaries.
module rgb_pwm_driver #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] val_red,
  input  logic [WIDTH-1:0] val_green,
  input  logic [WIDTH-1:0] val_blue,
  output logic             led_red,
  output logic             led_green,
  output logic             led_blue,
  output logic             period_start
);

  localparam int MAXSTEP = (1 << WIDTH) - 1;
  localparam int PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] STEP_LAST  = WIDTH'(MAXSTEP - 1);

  logic [2:0][WIDTH-1:0] valIn;
  logic [2:0][WIDTH-1:0] sync1;
  logic [2:0][WIDTH-1:0] sync2;
  logic [2:0][WIDTH-1:0] sync3;
  logic [2:0][WIDTH-1:0] shadow;
  logic [2:0][WIDTH-1:0] duty;
  logic [PW-1:0]         prescCnt;
  logic [WIDTH-1:0]      stepCnt;
  logic                  tick;
  logic                  periodEnd;
  logic [2:0]            ledNext;

  assign valIn     = {val_blue, val_green, val_red};
  assign tick      = (prescCnt == PRESC_LAST);
  assign periodEnd = tick && (stepCnt == STEP_LAST);

  // Shadow only follows a value seen unchanged on two consecutive samples,
  // so a multi-bit value caught mid-transition is never taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      shadow <= '0;
    end else begin
      sync1 <= valIn;
      sync2 <= sync1;
      sync3 <= sync2;
      for (int c = 0; c < 3; c++) begin
        if (sync2[c] == sync3[c]) begin
          shadow[c] <= sync2[c];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescCnt     <= '0;
      stepCnt      <= '0;
      duty         <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= 1'b0;
      prescCnt     <= tick ? '0 : prescCnt + 1'b1;
      if (periodEnd) begin
        stepCnt      <= '0;
        duty         <= shadow;
        period_start <= 1'b1;
      end else if (tick) begin
        stepCnt <= stepCnt + 1'b1;
      end
    end
  end

  // stepCnt never exceeds MAXSTEP-1, so an all-ones duty keeps the LED high.
  always_comb begin
    ledNext = '0;
    for (int c = 0; c < 3; c++) begin
      ledNext[c] = (stepCnt < duty[c]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_red   <= 1'b0;
      led_green <= 1'b0;
      led_blue  <= 1'b0;
    end else begin
      led_red   <= ledNext[0];
      led_green <= ledNext[1];
      led_blue  <= ledNext[2];
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: checks rgb_pwm_driver (PRESCALE=2 and PRESCALE=1 builds)
// against a position-within-period model of the PWM waveform.
module tb_rgb_pwm_driver;

  localparam int P    = 2;
  localparam int PER  = 15 * P;
  localparam int PER2 = 15;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] valRed = '0, valGreen = '0, valBlue = '0;
  logic [3:0] val2Red = '0, val2Green = '0, val2Blue = '0;
  logic       ledRed, ledGreen, ledBlue, periodStart;
  logic       led2Red, led2Green, led2Blue, periodStart2;
  wire  [2:0] leds = {ledBlue, ledGreen, ledRed};

  int errors = 0;
  int checks = 0;

  // Model state: n = clk edges since reset release, cur = duty in force,
  // settled = value the inputs have been held at long enough to be captured.
  int n = 0;
  int cur[3];
  int settled[3];
  int cur2 = 0;
  int settled2 = 0;
  bit expLed[3];
  bit expPs;
  bit expLed2;
  bit expPs2;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.WIDTH(4), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset),
    .val_red(valRed), .val_green(valGreen), .val_blue(valBlue),
    .led_red(ledRed), .led_green(ledGreen), .led_blue(ledBlue),
    .period_start(periodStart)
  );

  rgb_pwm_driver #(.WIDTH(4), .PRESCALE(1)) dut2 (
    .clk(clk), .reset(reset),
    .val_red(val2Red), .val_green(val2Green), .val_blue(val2Blue),
    .led_red(led2Red), .led_green(led2Green), .led_blue(led2Blue),
    .period_start(periodStart2)
  );

  task automatic restartModel();
    n = 0;
    for (int c = 0; c < 3; c++) cur[c] = 0;
    cur2 = 0;
  endtask

  // Advance one clk and work out what every output should now show.
  task automatic tick();
    int q;
    int q2;
    @(posedge clk);
    #1;
    n++;
    q = ((n - 1) % PER) + 1;
    for (int c = 0; c < 3; c++) expLed[c] = (q <= P * cur[c]);
    expPs = (n % PER == 0);
    if (n % PER == 0) begin
      for (int c = 0; c < 3; c++) cur[c] = settled[c];
    end
    q2 = ((n - 1) % PER2) + 1;
    expLed2 = (q2 <= cur2);
    expPs2  = (n % PER2 == 0);
    if (n % PER2 == 0) cur2 = settled2;
  endtask

  task automatic waitPos(input int q);
    while (n % PER != q) tick();
  endtask

  task automatic setVals(input int r, input int g, input int b);
    valRed   = 4'(r);
    valGreen = 4'(g);
    valBlue  = 4'(b);
    settled[0] = r;
    settled[1] = g;
    settled[2] = b;
  endtask

  task automatic test_reset();
    int firstPs;
    #3;
    checks++;
    if ({ledRed, ledGreen, ledBlue, periodStart} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %b expected 0000", {ledRed, ledGreen, ledBlue, periodStart});
    end
    @(negedge clk);
    reset = 1'b0;
    restartModel();
    setVals(15, 0, 0);
    while (n < 40) begin
      tick();
      checks++;
      if (periodStart !== expPs) begin
        errors++;
        $display("[TB] FAIL first_run_ps n=%0d: got %b expected %b", n, periodStart, expPs);
      end
    end
    checks++;
    if (ledRed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_led_red: got %b expected 1", ledRed);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ledRed, ledGreen, ledBlue, periodStart} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b expected 0000", {ledRed, ledGreen, ledBlue, periodStart});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    restartModel();
    firstPs = -1;
    while (n < 35) begin
      tick();
      if (periodStart === 1'b1 && firstPs < 0) firstPs = n;
    end
    checks++;
    if (firstPs != 30) begin
      errors++;
      $display("[TB] FAIL first_period_start: got clk %0d expected clk 30", firstPs);
    end
  endtask

  task automatic test_steady();
    int cnt[3];
    waitPos(5);
    setVals(0, 15, 5);
    waitPos(0);
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    for (int t = 0; t < PER; t++) begin
      tick();
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (leds[c] !== expLed[c]) begin
          errors++;
          $display("[TB] FAIL steady_led%0d n=%0d: got %b expected %b", c, n, leds[c], expLed[c]);
        end
        if (leds[c] === 1'b1) cnt[c]++;
      end
    end
    checks++;
    if (cnt[0] != 0 || cnt[1] != 30 || cnt[2] != 10) begin
      errors++;
      $display("[TB] FAIL steady_counts: got r=%0d g=%0d b=%0d expected r=0 g=30 b=10", cnt[0], cnt[1], cnt[2]);
    end
  endtask

  task automatic test_period_pulse();
    int lastPs;
    bit prevBlue;
    lastPs = n;
    prevBlue = ledBlue;
    for (int t = 0; t < 3 * PER; t++) begin
      tick();
      checks++;
      if (periodStart !== expPs) begin
        errors++;
        $display("[TB] FAIL pulse_ps n=%0d: got %b expected %b", n, periodStart, expPs);
      end
      if (periodStart === 1'b1) begin
        checks++;
        if (n - lastPs != PER) begin
          errors++;
          $display("[TB] FAIL pulse_spacing: got %0d expected %0d", n - lastPs, PER);
        end
        lastPs = n;
      end
      if (ledBlue === 1'b1 && !prevBlue) begin
        checks++;
        if (n != lastPs + 1) begin
          errors++;
          $display("[TB] FAIL rise_align: got clk %0d expected clk %0d", n, lastPs + 1);
        end
      end
      prevBlue = ledBlue;
    end
  endtask

  task automatic test_midchange();
    int cntA;
    int cntB;
    cntA = 0;
    cntB = 0;
    waitPos(0);
    for (int t = 0; t < 2 * PER; t++) begin
      tick();
      if (n % PER == 15 && t < PER) setVals(0, 15, 9);
      checks++;
      if (ledBlue !== expLed[2]) begin
        errors++;
        $display("[TB] FAIL mid_led_blue n=%0d: got %b expected %b", n, ledBlue, expLed[2]);
      end
      if (ledBlue === 1'b1) begin
        if (t < PER) cntA++;
        else cntB++;
      end
    end
    checks++;
    if (cntA != 10) begin
      errors++;
      $display("[TB] FAIL mid_current_period: got %0d high expected 10", cntA);
    end
    checks++;
    if (cntB != 18) begin
      errors++;
      $display("[TB] FAIL mid_next_period: got %0d high expected 18", cntB);
    end
  endtask

  task automatic test_toggle();
    int cnt;
    waitPos(5);
    for (int t = 0; t < 2 * PER; t++) begin
      valRed = (t % 2 == 0) ? 4'd3 : 4'd12;
      tick();
      checks++;
      if (ledRed !== 1'b0 || ledRed !== expLed[0]) begin
        errors++;
        $display("[TB] FAIL toggle_led_red n=%0d: got %b expected 0", n, ledRed);
      end
    end
    setVals(12, 15, 9);
    waitPos(0);
    cnt = 0;
    for (int t = 0; t < PER; t++) begin
      tick();
      checks++;
      if (ledRed !== expLed[0]) begin
        errors++;
        $display("[TB] FAIL hold_led_red n=%0d: got %b expected %b", n, ledRed, expLed[0]);
      end
      if (ledRed === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 24) begin
      errors++;
      $display("[TB] FAIL hold_red_count: got %0d high expected 24", cnt);
    end
  endtask

  task automatic test_prescale1();
    int cnt;
    while (n % PER2 != 3) tick();
    val2Green = 4'd1;
    settled2  = 1;
    while (n % PER2 != 0) tick();
    for (int p = 0; p < 3; p++) begin
      cnt = 0;
      for (int t = 0; t < PER2; t++) begin
        tick();
        checks++;
        if (led2Green !== expLed2 || periodStart2 !== expPs2) begin
          errors++;
          $display("[TB] FAIL p1_outputs n=%0d: got led=%b ps=%b expected led=%b ps=%b",
                   n, led2Green, periodStart2, expLed2, expPs2);
        end
        if (led2Green === 1'b1) cnt++;
      end
      checks++;
      if (cnt != 1) begin
        errors++;
        $display("[TB] FAIL p1_count: got %0d high expected 1", cnt);
      end
    end
  endtask

  task automatic test_random();
    int changeQ;
    int dEff[3];
    int cnt[3];
    waitPos(0);
    for (int p = 0; p < 8; p++) begin
      changeQ = $urandom_range(18, 2);
      for (int c = 0; c < 3; c++) begin
        dEff[c] = cur[c];
        cnt[c] = 0;
      end
      for (int t = 0; t < PER; t++) begin
        tick();
        if (n % PER == changeQ) begin
          setVals($urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0));
        end
        for (int c = 0; c < 3; c++) begin
          checks++;
          if (leds[c] !== expLed[c]) begin
            errors++;
            $display("[TB] FAIL rand_led%0d n=%0d: got %b expected %b", c, n, leds[c], expLed[c]);
          end
          if (leds[c] === 1'b1) cnt[c]++;
        end
        checks++;
        if (periodStart !== expPs) begin
          errors++;
          $display("[TB] FAIL rand_ps n=%0d: got %b expected %b", n, periodStart, expPs);
        end
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (cnt[c] != P * dEff[c]) begin
          errors++;
          $display("[TB] FAIL rand_count%0d: got %0d high expected %0d", c, cnt[c], P * dEff[c]);
        end
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      cur[c] = 0;
      settled[c] = 0;
    end
    test_reset();
    test_steady();
    test_period_pulse();
    test_midchange();
    test_toggle();
    test_prescale1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no completion expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
